pdua_control_unit: RTL
======================

# pdua_control_unit

Microprogrammed Moore control unit that drives every control input of the PDUA datapath (`PDUA`, MAX_WIDTH 8 / ADDR_WIDTH 3) and consumes its outputs (`out_IR`, flags C/N/P/Z). It replaces hand-driven control vectors with an automatic fetch–decode–execute sequencer. It sits beside `PDUA` at the top level and connects port-for-port to its control pins.

## Interface
- `ADDR_WIDTH`, 3: register-bank address width; sets the width of BusB_addr and BusC_addr.
- `PC_ADDR`, 0: register-bank index of the PC.
- `ACC_ADDR`, 1: register-bank index of the accumulator.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  leaves IDLE; sampled only in IDLE.
- `out_IR`  in  5  opcode from the datapath IR.
- `C`, `N`, `P`, `Z`  in  1 each  datapath flags.
- `wr_rdn`, `enaf`, `sclr`, `ir_en`, `mar_en`, `mdr_en`, `mdr_alu_n`, `bank_wr_en`  out  1 each  datapath controls.
- `selop`  out  3  ALU operation.
- `shamt`  out  2  shift amount.
- `BusB_addr`, `BusC_addr`  out  ADDR_WIDTH  register-bank read and write addresses.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky flag: an undefined opcode was decoded.
- `state_dbg`  out  4  current state encoding.

## Operation
- **Output style.** Moore: outputs decode only from the state register and `op_r`. `op_r` is a 5-bit opcode latched in DECODE.
- **Default outputs.** All 1-bit controls are 0 except where a state lists them. `selop=000`, `shamt=00`, `BusB_addr=BusC_addr=PC_ADDR`, `wr_rdn=0` (read only; this block issues no memory writes).
- **States and their outputs:**
  - IDLE: `sclr=1`.
  - FETCH_A: `mar_en=1`, BusB=PC, `selop=000`.
  - FETCH_B: `mdr_en=1`, `bank_wr_en=1`, `selop=110`, BusC=PC (PC←PC+1).
  - FETCH_C: `ir_en=1`, `mdr_alu_n=1`.
  - DECODE: no enables; latches `op_r←out_IR`; samples flags.
  - EX_ALU: BusB=BusC=ACC, `bank_wr_en=1`, `enaf=1`, `mdr_alu_n=0`, `selop/shamt` per opcode.
  - OP_A: same as FETCH_A.
  - OP_B: same as FETCH_B.
  - OP_C: `bank_wr_en=1`, `mdr_alu_n=1`, BusC=ACC (LDI) or PC (jumps).
  - SKIP: same as FETCH_B (skip the operand byte).
  - HALT: none.
- **Opcode map:**
  - `00sss`: ALU op, `selop=sss`, `shamt=00`.
  - `100ss`: shift, `selop=111`, `shamt=ss`.
  - `01000`: LDI.
  - `01010`: JMP.
  - `01011` / `01100` / `01101`: JZ / JN / JC.
  - `11111`: HALT.
  - All other codes: NOP and set `illegal`.
  - `00000` is a legal ALU op, not a NOP.
- **Transitions:**
  - IDLE → FETCH_A when `start=1`.
  - FETCH_A → FETCH_B → FETCH_C → DECODE.
  - DECODE, ALU/shift → EX_ALU → FETCH_A.
  - DECODE, LDI/JMP → OP_A → OP_B → OP_C → FETCH_A.
  - DECODE, Jcc with flag true → OP_A (taken path). Flag false → SKIP → FETCH_A.
  - DECODE, HALT → HALT. HALT is left only by reset.
  - DECODE, illegal → FETCH_A.
- **Flag use.** Flags are those present during the DECODE cycle, i.e. the result of the previous EX_ALU. LDI does not update flags.
- **`illegal`.** Set in DECODE; cleared only by reset or in IDLE.

## Timing
- **Reset.** Asserting `rst` low forces IDLE immediately, including mid-instruction, with no completion of the partial instruction. Outputs then equal IDLE values: `sclr=1`, all else 0/default, `halted=0`, `illegal=0`, `state_dbg=0`.
- **Cycles per instruction (FETCH_A to the next FETCH_A):**
  - ALU/shift: 5.
  - NOP/illegal: 4.
  - LDI, JMP, taken Jcc: 7.
  - Not-taken Jcc: 5.
- **`out_IR`** must be stable from the edge ending FETCH_C until DECODE ends. `op_r` holds the opcode for the rest of the instruction.
- **`start`** asserted in any state other than IDLE is ignored.
- **PC wrap.** PC increments in FETCH_B, OP_B and SKIP and wrap modulo 2^8 inside the datapath; the control unit does not track the PC.
- **Fixed write address.** `bank_wr_en` is never asserted in the same cycle as a change of BusC_addr away from its state value.

## Test plan
- Reset low, then high with `start=1` → `sclr=1` in IDLE; FETCH_A exactly one edge later with `mar_en=1`; `state_dbg` sequence 0,1,2,3,4.
- `out_IR=00011` at DECODE → one EX_ALU cycle with `selop=011`, `enaf=1`, `bank_wr_en=1`, BusC=1; FETCH_A 5 cycles after the previous FETCH_A.
- `out_IR=10010` → EX_ALU with `selop=111`, `shamt=10`.
- LDI then JMP → each takes 7 cycles; OP_C shows `mdr_alu_n=1` with BusC=1 (LDI) and BusC=0 (JMP).
- JZ with Z=1 → OP_A path, 7 cycles. JZ with Z=0 → SKIP, 5 cycles.
- `out_IR=10111` → `illegal=1` from the next cycle, stays high through the following instructions. `out_IR=11111` → `halted=1`, state holds 10+ cycles; `rst` pulsed low mid-OP_B → immediate IDLE, `illegal=0`.

Source files
------------

// File: rtl/pdua_control_unit.sv
// rtl/pdua_control_unit.sv - Moore fetch/decode/execute sequencer for the PDUA datapath
module pdua_control_unit #(
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(0),
  parameter logic [ADDR_WIDTH-1:0] ACC_ADDR   = ADDR_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            out_IR,
  input  logic                  C,
  input  logic                  N,
  input  logic                  P,
  input  logic                  Z,
  output logic                  wr_rdn,
  output logic                  enaf,
  output logic                  sclr,
  output logic                  ir_en,
  output logic                  mar_en,
  output logic                  mdr_en,
  output logic                  mdr_alu_n,
  output logic                  bank_wr_en,
  output logic [2:0]            selop,
  output logic [1:0]            shamt,
  output logic [ADDR_WIDTH-1:0] BusB_addr,
  output logic [ADDR_WIDTH-1:0] BusC_addr,
  output logic                  halted,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH_A = 4'd1;
  localparam logic [3:0] S_FETCH_B = 4'd2;
  localparam logic [3:0] S_FETCH_C = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_EX_ALU  = 4'd5;
  localparam logic [3:0] S_OP_A    = 4'd6;
  localparam logic [3:0] S_OP_B    = 4'd7;
  localparam logic [3:0] S_OP_C    = 4'd8;
  localparam logic [3:0] S_SKIP    = 4'd9;
  localparam logic [3:0] S_HALT    = 4'd10;

  localparam logic [4:0] OP_LDI  = 5'b01000;
  localparam logic [4:0] OP_JMP  = 5'b01010;
  localparam logic [4:0] OP_JZ   = 5'b01011;
  localparam logic [4:0] OP_JN   = 5'b01100;
  localparam logic [4:0] OP_JC   = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic [3:0] state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  // Opcode classes of the word currently on the IR (valid during DECODE)
  logic ir_alu, ir_shift, ir_ldi_jmp, ir_jcc, ir_halt, ir_illegal, jcc_taken;
  // P is part of the datapath flag bundle but no instruction tests it
  logic unused_flag_p;
  assign unused_flag_p = P;

  assign ir_alu     = (out_IR[4:3] == 2'b00);
  assign ir_shift   = (out_IR[4:2] == 3'b100);
  assign ir_ldi_jmp = (out_IR == OP_LDI) || (out_IR == OP_JMP);
  assign ir_jcc     = (out_IR == OP_JZ) || (out_IR == OP_JN) || (out_IR == OP_JC);
  assign ir_halt    = (out_IR == OP_HALT);
  assign ir_illegal = !(ir_alu || ir_shift || ir_ldi_jmp || ir_jcc || ir_halt);

  // Condition selected by the conditional-jump opcode, using flags seen in DECODE
  always_comb begin
    jcc_taken = 1'b0;
    case (out_IR)
      OP_JZ:   jcc_taken = Z;
      OP_JN:   jcc_taken = N;
      OP_JC:   jcc_taken = C;
      default: jcc_taken = 1'b0;
    endcase
  end

  // Next-state, opcode latch and sticky illegal flag
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        illegal_d = 1'b0;
        if (start) state_d = S_FETCH_A;
      end
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: state_d = S_FETCH_C;
      S_FETCH_C: state_d = S_DECODE;
      S_DECODE: begin
        op_d = out_IR;
        if (ir_alu || ir_shift)  state_d = S_EX_ALU;
        else if (ir_ldi_jmp)     state_d = S_OP_A;
        else if (ir_jcc)         state_d = jcc_taken ? S_OP_A : S_SKIP;
        else if (ir_halt)        state_d = S_HALT;
        else begin
          state_d   = S_FETCH_A;
          illegal_d = 1'b1;
        end
      end
      S_EX_ALU: state_d = S_FETCH_A;
      S_OP_A:   state_d = S_OP_B;
      S_OP_B:   state_d = S_OP_C;
      S_OP_C:   state_d = S_FETCH_A;
      S_SKIP:   state_d = S_FETCH_A;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any partial instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode from state and latched opcode only
  always_comb begin
    enaf       = 1'b0;
    sclr       = 1'b0;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    mdr_alu_n  = 1'b0;
    bank_wr_en = 1'b0;
    selop      = 3'b000;
    shamt      = 2'b00;
    BusB_addr  = PC_ADDR;
    BusC_addr  = PC_ADDR;
    case (state_q)
      S_IDLE: sclr = 1'b1;
      S_FETCH_A, S_OP_A: begin
        mar_en    = 1'b1;
        BusB_addr = PC_ADDR;
      end
      // PC <- PC + 1 while the addressed byte lands in MDR
      S_FETCH_B, S_OP_B, S_SKIP: begin
        mdr_en     = 1'b1;
        bank_wr_en = 1'b1;
        selop      = 3'b110;
        BusC_addr  = PC_ADDR;
      end
      S_FETCH_C: begin
        ir_en     = 1'b1;
        mdr_alu_n = 1'b1;
      end
      S_EX_ALU: begin
        BusB_addr  = ACC_ADDR;
        BusC_addr  = ACC_ADDR;
        bank_wr_en = 1'b1;
        enaf       = 1'b1;
        if (op_q[4:3] == 2'b00) begin
          selop = op_q[2:0];
        end else begin
          selop = 3'b111;
          shamt = op_q[1:0];
        end
      end
      // Operand byte goes to ACC for LDI, to PC for every jump
      S_OP_C: begin
        bank_wr_en = 1'b1;
        mdr_alu_n  = 1'b1;
        BusC_addr  = (op_q == OP_LDI) ? ACC_ADDR : PC_ADDR;
      end
      default: ;
    endcase
  end

  assign wr_rdn    = 1'b0;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule
